// File: rtl/proc_pkg.sv
// ---------------------------------------------------------------------------
// proc_pkg
//
// Shared definitions for the 8-bit 3BC processor's memory path.
//   DW          : processor data width (one byte).
//   MAX_AW      : widest data-memory address the request record can carry.
//   mem_state_t : data-memory controller FSM states.
//   mem_req_t   : a request captured from the core at acceptance.
// ---------------------------------------------------------------------------
package proc_pkg;

  localparam int DW     = 8;
  localparam int MAX_AW = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } mem_state_t;

  // The address field is sized for the widest supported array. Narrower
  // instances zero-extend into it and use only the low AW bits.
  typedef struct packed {
    logic              write;
    logic [MAX_AW-1:0] addr;
    logic [DW-1:0]     wdata;
  } mem_req_t;

endpackage : proc_pkg

// File: rtl/data_mem_array.sv
// ---------------------------------------------------------------------------
// data_mem_array
//
// 2^AW x DW byte storage for the data-memory controller.
//   clk   in  : write clock.
//   we    in  : write enable, array[addr] <= wdata on the rising edge.
//   addr  in  : byte address shared by the write and the read port.
//   wdata in  : write data.
//   rdata out : combinational read of array[addr].
// ---------------------------------------------------------------------------
module data_mem_array
  import proc_pkg::*;
#(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  localparam int DEPTH = 2 ** AW;

  logic [DW-1:0] mem [DEPTH];

  // NOTE: storage carries no reset so it maps onto RAM; its contents after
  // power-up or reset are whatever was there before.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule : data_mem_array

// File: rtl/data_mem_ctrl.sv
// ---------------------------------------------------------------------------
// data_mem_ctrl
//
// Multi-cycle data-memory controller for the 3BC core. Takes one load or
// store at a time over a valid/ready handshake, performs it LAT cycles after
// acceptance and pulses RspValid in the following cycle.
//
//   Clk      in  : clock, all state changes on the rising edge.
//   Reset_n  in  : asynchronous active-low reset.
//   ReqValid in  : core presents a request.
//   ReqReady out : a request can be accepted this cycle (IDLE or RESP).
//   ReqWrite in  : 1 = store, 0 = load.
//   ReqAddr  in  : byte address.
//   ReqWData in  : store data.
//   RspValid out : one-cycle completion pulse for loads and stores.
//   RspData  out : last load result, feeds the writeback mux memory input.
//   Busy     out : request in flight (ACCESS), stalls the core.
// ---------------------------------------------------------------------------
module data_mem_ctrl
  import proc_pkg::*;
#(
  parameter int AW  = 8,
  parameter int LAT = 2
) (
  input  logic          Clk,
  input  logic          Reset_n,
  input  logic          ReqValid,
  output logic          ReqReady,
  input  logic          ReqWrite,
  input  logic [AW-1:0] ReqAddr,
  input  logic [DW-1:0] ReqWData,
  output logic          RspValid,
  output logic [DW-1:0] RspData,
  output logic          Busy
);

  // -------------------------------------------------------------------------
  // Parameter legality, checked while elaborating.
  // -------------------------------------------------------------------------
  if (LAT < 1 || LAT > 15) begin : g_bad_lat
    $error("data_mem_ctrl: LAT=%0d is outside the legal range 1..15", LAT);
  end

  if (AW < 1 || AW > MAX_AW) begin : g_bad_aw
    $error("data_mem_ctrl: AW=%0d is outside the legal range 1..%0d", AW, MAX_AW);
  end

  localparam logic [3:0] CNT_LOAD = 4'(LAT - 1);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  mem_state_t    state_q;
  mem_state_t    state_d;
  logic [3:0]    cnt_q;
  mem_req_t      req_q;
  logic [DW-1:0] rsp_data_q;

  logic          accept;
  logic          op_done;
  logic          mem_we;
  logic          load_done;
  logic [DW-1:0] mem_rdata;

  assign ReqReady  = (state_q == IDLE) || (state_q == RESP);
  assign accept    = ReqValid && ReqReady;

  // The access completes on the edge where the countdown has reached zero.
  assign op_done   = (state_q == ACCESS) && (cnt_q == 4'd0);
  assign mem_we    = op_done &&  req_q.write;
  assign load_done = op_done && !req_q.write;

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  // NOTE: every variable driven here gets a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
        end
      end
      RESP: begin
        // Back-to-back: a new request taken in the response cycle goes
        // straight into its own access.
        state_d = accept ? ACCESS : IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Sequential logic
  // -------------------------------------------------------------------------
  // NOTE: registers are updated with non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Request latch and latency counter. Inputs are captured only at accept,
  // so the core may change them freely while the access is in flight.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      req_q <= '0;
      cnt_q <= 4'd0;
    end else if (accept) begin
      req_q.write <= ReqWrite;
      req_q.addr  <= MAX_AW'(ReqAddr);
      req_q.wdata <= ReqWData;
      cnt_q       <= CNT_LOAD;
    end else if ((state_q == ACCESS) && (cnt_q != 4'd0)) begin
      cnt_q <= cnt_q - 4'd1;
    end
  end

  // Load result register: moves only when a load completes, so stores and
  // idle cycles leave the writeback mux input untouched.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rsp_data_q <= '0;
    end else if (load_done) begin
      rsp_data_q <= mem_rdata;
    end
  end

  // -------------------------------------------------------------------------
  // Storage
  // -------------------------------------------------------------------------
  // The array is addressed only from the latched request; because a store
  // writes at its completion edge, a later load to the same byte already
  // reads the new value.
  data_mem_array #(
    .AW(AW)
  ) u_array (
    .clk   (Clk),
    .we    (mem_we),
    .addr  (req_q.addr[AW-1:0]),
    .wdata (req_q.wdata),
    .rdata (mem_rdata)
  );

  // Address bits above AW are always zero; folding them here keeps the
  // whole request record consumed.
  logic unused_addr_bits;
  assign unused_addr_bits = ^req_q.addr;

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign RspValid = (state_q == RESP);
  assign Busy     = (state_q == ACCESS);
  assign RspData  = rsp_data_q;

endmodule : data_mem_ctrl

// File: tb/tb_data_mem_ctrl.sv
// ---------------------------------------------------------------------------
// tb_data_mem_ctrl
//
// Bench for data_mem_ctrl. Four instances share the clock, reset and the
// request address/data/write lines; each has its own ReqValid:
//   index 0 : LAT = 2  (vector table, back-to-back held request)
//   index 1 : LAT = 1
//   index 2 : LAT = 15
//   index 3 : LAT = 4  (reset in the middle of a store)
// Inputs change 1 time unit after a rising edge; outputs are sampled on
// the falling edge.
// ---------------------------------------------------------------------------
module tb_data_mem_ctrl;

  localparam int NINST = 4;
  localparam int LAT_OF [NINST] = '{2, 1, 15, 4};

  typedef struct {
    logic       write;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rsp;   // RspData expected in the RESP cycle
  } vec_t;

  logic             Clk;
  logic             Reset_n;
  logic [NINST-1:0] req_valid;
  logic             req_write;
  logic [7:0]       req_addr;
  logic [7:0]       req_wdata;
  logic [NINST-1:0] req_ready;
  logic [NINST-1:0] rsp_valid;
  logic [NINST-1:0] busy;
  logic [7:0]       rsp_data [NINST];

  int passed = 0;
  int total  = 0;

  data_mem_ctrl #(.AW(8), .LAT(2)) u_lat2 (
    .Clk(Clk), .Reset_n(Reset_n), .ReqValid(req_valid[0]), .ReqReady(req_ready[0]),
    .ReqWrite(req_write), .ReqAddr(req_addr), .ReqWData(req_wdata),
    .RspValid(rsp_valid[0]), .RspData(rsp_data[0]), .Busy(busy[0])
  );

  data_mem_ctrl #(.AW(8), .LAT(1)) u_lat1 (
    .Clk(Clk), .Reset_n(Reset_n), .ReqValid(req_valid[1]), .ReqReady(req_ready[1]),
    .ReqWrite(req_write), .ReqAddr(req_addr), .ReqWData(req_wdata),
    .RspValid(rsp_valid[1]), .RspData(rsp_data[1]), .Busy(busy[1])
  );

  data_mem_ctrl #(.AW(8), .LAT(15)) u_lat15 (
    .Clk(Clk), .Reset_n(Reset_n), .ReqValid(req_valid[2]), .ReqReady(req_ready[2]),
    .ReqWrite(req_write), .ReqAddr(req_addr), .ReqWData(req_wdata),
    .RspValid(rsp_valid[2]), .RspData(rsp_data[2]), .Busy(busy[2])
  );

  data_mem_ctrl #(.AW(8), .LAT(4)) u_lat4 (
    .Clk(Clk), .Reset_n(Reset_n), .ReqValid(req_valid[3]), .ReqReady(req_ready[3]),
    .ReqWrite(req_write), .ReqAddr(req_addr), .ReqWData(req_wdata),
    .RspValid(rsp_valid[3]), .RspData(rsp_data[3]), .Busy(busy[3])
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Hard stop in case something upstream wedges the run.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) begin
      passed++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One complete request on instance idx: checks the idle handshake, then
  // {Busy, RspValid, ReqReady} for each of the LAT+1 cycles after accept and
  // RspData in the response cycle. Request inputs are scrambled right after
  // acceptance to show they are not re-sampled. Starts and ends 1 unit
  // after a rising edge.
  task automatic do_op(input int idx, input logic w, input logic [7:0] a,
                       input logic [7:0] d, input logic [7:0] exp_rsp, input string tag);
    int lat;
    lat       = LAT_OF[idx];
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    req_valid[idx] = 1'b1;
    @(negedge Clk);
    check({tag, " idle busy/rsp/ready"},
          {29'd0, busy[idx], rsp_valid[idx], req_ready[idx]}, 32'b001);
    @(posedge Clk);
    #1;
    req_valid[idx] = 1'b0;
    req_write = ~w;
    req_addr  = ~a;
    req_wdata = ~d;
    for (int k = 1; k <= lat + 1; k++) begin
      @(negedge Clk);
      check($sformatf("%s c%0d busy/rsp/ready", tag, k),
            {29'd0, busy[idx], rsp_valid[idx], req_ready[idx]},
            {29'd0, (k <= lat), (k == lat + 1), (k == lat + 1)});
      if (k == lat + 1) begin
        check({tag, " rsp_data"}, {24'd0, rsp_data[idx]}, {24'd0, exp_rsp});
      end
      @(posedge Clk);
      #1;
    end
  endtask

  vec_t vecs [10];

  initial begin
    // Hand-computed sequence for the LAT=2 instance; RspData starts at 00
    // and moves only on loads.
    vecs[0] = '{1'b1, 8'h10, 8'hA5, 8'h00};
    vecs[1] = '{1'b0, 8'h10, 8'h00, 8'hA5};
    vecs[2] = '{1'b1, 8'h00, 8'h11, 8'hA5};
    vecs[3] = '{1'b1, 8'h01, 8'h22, 8'hA5};
    vecs[4] = '{1'b0, 8'h00, 8'h00, 8'h11};
    vecs[5] = '{1'b1, 8'hFF, 8'hFF, 8'h11};
    vecs[6] = '{1'b0, 8'hFF, 8'h00, 8'hFF};
    vecs[7] = '{1'b0, 8'h01, 8'h00, 8'h22};
    vecs[8] = '{1'b1, 8'h10, 8'h00, 8'h22};
    vecs[9] = '{1'b0, 8'h10, 8'h00, 8'h00};

    Reset_n   = 1'b0;
    req_valid = '0;
    req_write = 1'b0;
    req_addr  = 8'h00;
    req_wdata = 8'h00;

    // ---- reset values ----
    #3;
    for (int i = 0; i < NINST; i++) begin
      check($sformatf("reset[%0d] busy/rsp/ready", i),
            {29'd0, busy[i], rsp_valid[i], req_ready[i]}, 32'b001);
      check($sformatf("reset[%0d] rsp_data", i), {24'd0, rsp_data[i]}, 32'h00);
    end
    @(negedge Clk);
    Reset_n = 1'b1;
    @(posedge Clk);
    #1;

    // ---- vector table, LAT = 2 ----
    for (int v = 0; v < 10; v++) begin
      do_op(0, vecs[v].write, vecs[v].addr, vecs[v].wdata, vecs[v].exp_rsp,
            $sformatf("vec%0d", v));
    end

    // ---- back-to-back held request, LAT = 2: loads of 00 then 01 ----
    req_write = 1'b0;
    req_addr  = 8'h00;
    req_valid[0] = 1'b1;
    @(negedge Clk);
    check("b2b idle ready", {31'd0, req_ready[0]}, 32'd1);
    @(posedge Clk);
    #1;
    req_addr = 8'h01;   // next request presented and held during ACCESS
    for (int k = 1; k <= 6; k++) begin
      @(negedge Clk);
      check($sformatf("b2b c%0d busy/rsp/ready", k),
            {29'd0, busy[0], rsp_valid[0], req_ready[0]},
            (k == 3 || k == 6) ? 32'b011 : 32'b100);
      if (k == 3) check("b2b first rsp_data", {24'd0, rsp_data[0]}, 32'h11);
      if (k == 6) check("b2b second rsp_data", {24'd0, rsp_data[0]}, 32'h22);
      @(posedge Clk);
      #1;
      if (k == 3) begin
        req_valid[0] = 1'b0;
        req_addr     = 8'hFF;
      end
    end

    // ---- LAT = 1 and LAT = 15 ----
    do_op(1, 1'b1, 8'h05, 8'h77, 8'h00, "lat1 store");
    do_op(1, 1'b0, 8'h05, 8'h00, 8'h77, "lat1 load");
    do_op(2, 1'b1, 8'h80, 8'h9C, 8'h00, "lat15 store");
    do_op(2, 1'b0, 8'h80, 8'h00, 8'h9C, "lat15 load");

    // ---- reset during a store, LAT = 4 ----
    do_op(3, 1'b1, 8'h20, 8'h5A, 8'h00, "rst prior store");
    do_op(3, 1'b0, 8'h20, 8'h00, 8'h5A, "rst prior load");
    req_write = 1'b1;
    req_addr  = 8'h20;
    req_wdata = 8'h3C;
    req_valid[3] = 1'b1;
    @(posedge Clk);          // accept: closes cycle 0
    #1;
    req_valid[3] = 1'b0;
    @(posedge Clk);          // closes cycle 1
    #1;
    Reset_n = 1'b0;          // during cycle 2
    #1;
    check("rst mid busy/rsp/ready",
          {29'd0, busy[3], rsp_valid[3], req_ready[3]}, 32'b001);
    check("rst mid rsp_data", {24'd0, rsp_data[3]}, 32'h00);
    @(negedge Clk);
    #1;
    Reset_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge Clk);
      check($sformatf("rst after c%0d busy/rsp", k),
            {30'd0, busy[3], rsp_valid[3]}, 32'b00);
    end
    @(posedge Clk);
    #1;
    do_op(3, 1'b0, 8'h20, 8'h00, 8'h5A, "rst reload");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule : tb_data_mem_ctrl
